// File: rtl/stim_pkg.sv
// Shared types and constants for the stimulus pattern generator.
// The LFSR constants are used only when STIM_PATTERN_GEN_LFSR_EN is defined.
package stim_pkg;

   typedef enum logic [1:0] {
      MODE_TOGGLE = 2'b00,
      MODE_COUNT  = 2'b01,
      MODE_LFSR   = 2'b10,
      MODE_RSVD   = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_e;

   localparam int unsigned LFSR_W = 16;
   localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
   // Right-shifting Fibonacci form: bits 0,2,3,5 correspond to taps 16,14,13,11.
   localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'h002D;

   // One LFSR step: feedback enters at the MSB, register shifts right.
   function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
      return {^(s & LFSR_TAPS), s[LFSR_W-1:1]};
   endfunction

endpackage

// File: rtl/stim_ch_timer.sv
// Single-channel half-period timer: ticks every max(period,1) enabled cycles.
module stim_ch_timer
   import stim_pkg::*;
#(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             enable,
   input  logic [CNT_W-1:0] period,
   output logic             tick_c
);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] last;

   // Terminal count; a zero period behaves as a period of one.
   always_comb begin
      last = '0;
      if (period != '0) last = period - CNT_W'(1);
   end

   assign tick_c = enable && (cnt == last);

   // Counter clears on run entry, reloads to zero at terminal count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (enable) begin
         if (cnt == last) cnt <= '0;
         else             cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/stim_pattern_gen.sv
// Cycle-accurate stimulus generator: per-channel toggling or binary count,
// with start/stop/run-length control.
// Optional LFSR pattern mode (mode 10) is built when STIM_PATTERN_GEN_LFSR_EN is defined.
module stim_pattern_gen
   import stim_pkg::*;
#(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned CNT_W  = 8,
   parameter int unsigned RUN_W  = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic                    stop,
   input  logic [1:0]              mode,
   input  logic [NUM_CH*CNT_W-1:0] half_period,
   input  logic [RUN_W-1:0]        run_len,
   output logic [NUM_CH-1:0]       pattern,
   output logic                    busy,
   output logic                    done
);

   state_e                  state;
   mode_e                   mode_q;
   logic [NUM_CH*CNT_W-1:0] hp_q;
   logic [RUN_W-1:0]        run_len_q;
   logic [RUN_W-1:0]        run_cnt;
   logic [RUN_W-1:0]        run_cnt_nxt;
   logic [NUM_CH-1:0]       tick;
   logic [NUM_CH-1:0]       pattern_nxt;
   logic                    go;
   logic                    in_run;
`ifdef STIM_PATTERN_GEN_LFSR_EN
   logic [LFSR_W-1:0]       lfsr;
   logic [LFSR_W-1:0]       lfsr_nxt;
`endif

   assign go          = (state == IDLE) && start && !stop;
   assign in_run      = (state == RUN);
   assign run_cnt_nxt = run_cnt + RUN_W'(1);

   // One half-period timer per channel; channel 0 also paces count/LFSR stepping.
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      stim_ch_timer #(.CNT_W(CNT_W)) u_timer (
         .clk    (clk),
         .rst_n  (rst_n),
         .clear  (go),
         .enable (in_run),
         .period (hp_q[i*CNT_W +: CNT_W]),
         .tick_c (tick[i])
      );
   end

   // Next pattern for the current RUN cycle, selected by latched mode.
   always_comb begin
      pattern_nxt = pattern;
`ifdef STIM_PATTERN_GEN_LFSR_EN
      lfsr_nxt = lfsr;
      if (tick[0]) lfsr_nxt = lfsr_step(lfsr);
`endif
      case (mode_q)
         MODE_COUNT: if (tick[0]) pattern_nxt = pattern + NUM_CH'(1);
`ifdef STIM_PATTERN_GEN_LFSR_EN
         MODE_LFSR:  pattern_nxt = lfsr_nxt[NUM_CH-1:0];
`endif
         default:    pattern_nxt = pattern ^ tick;
      endcase
   end

   // Control FSM with registered pattern, busy and done.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         mode_q    <= MODE_TOGGLE;
         hp_q      <= '0;
         run_len_q <= '0;
         run_cnt   <= '0;
         pattern   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
`ifdef STIM_PATTERN_GEN_LFSR_EN
         lfsr      <= '0;
`endif
      end else begin
         done <= 1'b0;
         if (stop) begin
            state   <= IDLE;
            pattern <= '0;
            busy    <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     state     <= RUN;
                     busy      <= 1'b1;
                     mode_q    <= mode_e'(mode);
                     hp_q      <= half_period;
                     run_len_q <= run_len;
                     run_cnt   <= '0;
                     pattern   <= '0;
`ifdef STIM_PATTERN_GEN_LFSR_EN
                     lfsr      <= LFSR_SEED;
                     if (mode_e'(mode) == MODE_LFSR) pattern <= LFSR_SEED[NUM_CH-1:0];
`endif
                  end
               end
               RUN: begin
                  run_cnt <= run_cnt_nxt;
                  pattern <= pattern_nxt;
`ifdef STIM_PATTERN_GEN_LFSR_EN
                  lfsr    <= lfsr_nxt;
`endif
                  if ((run_len_q != '0) && (run_cnt_nxt == run_len_q)) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end
               DONE:    state <= IDLE;
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_stim_pattern_gen.sv
// Scoreboard bench for stim_pattern_gen: stimulus pushes per-cycle expectations,
// a negedge monitor pops and compares them.
module tb_stim_pattern_gen;

   localparam int unsigned NUM_CH = 4;
   localparam int unsigned CNT_W  = 8;
   localparam int unsigned RUN_W  = 16;

   logic                    clk;
   logic                    rst_n;
   logic                    start;
   logic                    stop;
   logic [1:0]              mode;
   logic [NUM_CH*CNT_W-1:0] half_period;
   logic [RUN_W-1:0]        run_len;
   logic [NUM_CH-1:0]       pattern;
   logic                    busy;
   logic                    done;

   int total = 0;
   int bad   = 0;

   logic [NUM_CH+1:0] exp_q[$];
   string             tag_q[$];
   logic [NUM_CH+1:0] e;
   string             t;

   localparam logic [31:0] HP_A = 32'h04030201;

   stim_pattern_gen #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .RUN_W(RUN_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .stop        (stop),
      .mode        (mode),
      .half_period (half_period),
      .run_len     (run_len),
      .pattern     (pattern),
      .busy        (busy),
      .done        (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected toggle-mode pattern j cycles after the RUN entry edge.
   function automatic logic [3:0] tog(input int j, input logic [31:0] hp);
      logic [3:0] r;
      int p;
      for (int c = 0; c < 4; c++) begin
         p = int'(hp[c*8 +: 8]);
         if (p == 0) p = 1;
         r[c] = ((j / p) % 2) == 1;
      end
      return r;
   endfunction

   // Push the expectation for the state just after the next rising edge.
   task automatic tick_chk(input logic [3:0] p, input logic b, input logic d, input string tag);
      @(posedge clk);
      #1;
      exp_q.push_back({p, b, d});
      tag_q.push_back(tag);
   endtask

   task automatic go(input logic [1:0] m, input logic [31:0] hp, input logic [15:0] rl);
      mode        = m;
      half_period = hp;
      run_len     = rl;
      start       = 1'b1;
   endtask

   // Monitor: compare DUT outputs against the oldest pending expectation.
   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         total++;
         if ({pattern, busy, done} !== e) begin
            bad++;
            $display("FAIL %s: got pattern=%h busy=%b done=%b, want pattern=%h busy=%b done=%b",
                     t, pattern, busy, done, e[5:2], e[1], e[0]);
         end
      end
   end

   initial begin
      logic [15:0] l;
      logic [3:0]  x;
      int          guard;

      rst_n       = 1'b0;
      start       = 1'b1;
      stop        = 1'b0;
      mode        = 2'b00;
      half_period = HP_A;
      run_len     = 16'd0;
      repeat (3) @(posedge clk);
      #3 start = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b1;
      tick_chk(4'h0, 1'b0, 1'b0, "reset0");
      tick_chk(4'h0, 1'b0, 1'b0, "reset1");

      // Toggle mode, free running; mid-run half_period change and start are ignored.
      go(2'b00, HP_A, 16'd0);
      tick_chk(tog(0, HP_A), 1'b1, 1'b0, "tog_entry");
      start = 1'b0;
      for (int j = 1; j < 24; j++) begin
         if (j == 6) half_period = 32'h07070707;
         start = (j == 9);
         tick_chk(tog(j, HP_A), 1'b1, 1'b0, "tog_run");
      end
      start = 1'b0;
      stop  = 1'b1;
      tick_chk(4'h0, 1'b0, 1'b0, "tog_stop");
      stop  = 1'b0;
      tick_chk(4'h0, 1'b0, 1'b0, "tog_no_done");

      // Binary count, P0=2, run_len=40.
      go(2'b01, 32'h09080702, 16'd40);
      tick_chk(4'h0, 1'b1, 1'b0, "cnt_entry");
      start = 1'b0;
      for (int j = 1; j < 40; j++) tick_chk(4'((j / 2) % 16), 1'b1, 1'b0, "cnt_run");
      tick_chk(4'h4, 1'b0, 1'b1, "cnt_done");
      tick_chk(4'h4, 1'b0, 1'b0, "cnt_hold0");
      tick_chk(4'h4, 1'b0, 1'b0, "cnt_hold1");

      // Zero half-periods behave as one; run_len=6.
      go(2'b00, 32'h00000000, 16'd6);
      tick_chk(4'h0, 1'b1, 1'b0, "hp0_entry");
      start = 1'b0;
      for (int j = 1; j < 6; j++) tick_chk(((j % 2) == 1) ? 4'hF : 4'h0, 1'b1, 1'b0, "hp0_run");
      tick_chk(4'h0, 1'b0, 1'b1, "hp0_done");
      tick_chk(4'h0, 1'b0, 1'b0, "hp0_idle");

      // start and stop together in IDLE: stays idle.
      start = 1'b1;
      stop  = 1'b1;
      tick_chk(4'h0, 1'b0, 1'b0, "start_stop0");
      start = 1'b0;
      stop  = 1'b0;
      tick_chk(4'h0, 1'b0, 1'b0, "start_stop1");

      // Mode 10: LFSR when built in, otherwise identical to toggle mode.
      go(2'b10, HP_A, 16'd10);
      l = 16'hACE1;
      for (int j = 0; j <= 11; j++) begin
`ifdef STIM_PATTERN_GEN_LFSR_EN
         x = l[3:0];
         if (j < 10) l = {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
`else
         x = tog((j > 10) ? 10 : j, HP_A);
`endif
         tick_chk(x, j < 10, j == 10, "mode10");
         start = 1'b0;
      end

      // Asynchronous reset mid-run; the run never resumes.
      go(2'b00, HP_A, 16'd0);
      tick_chk(4'h0, 1'b1, 1'b0, "arst_entry");
      start = 1'b0;
      tick_chk(tog(1, HP_A), 1'b1, 1'b0, "arst_run");
      @(posedge clk);
      #2 rst_n = 1'b0;
      exp_q.push_back({4'h0, 1'b0, 1'b0});
      tag_q.push_back("arst_mid");
      @(negedge clk);
      #2 rst_n = 1'b1;
      tick_chk(4'h0, 1'b0, 1'b0, "arst_after0");
      tick_chk(4'h0, 1'b0, 1'b0, "arst_after1");

      guard = 0;
      while (exp_q.size() != 0 && guard < 10) begin
         @(posedge clk);
         guard++;
      end
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
